booth_ctrl: RTL and testbench



---
 rtl/booth_ctrl.sv | 127 ++++++++++++
 tb/tb_booth_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_ctrl.sv
// booth_ctrl: Moore sequencer for the radix-2 Booth multiplier datapath of the 8-bit ALU.
// Latency: start sampled in IDLE -> LOAD next cycle; 2 or 3 cycles per iteration; DONE after last SHIFT.
// Backpressure: none; start is ignored while busy, no queuing.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 multiply request, sampled only in IDLE
//   abort                 (only with BOOTH_CTRL_ABORT_EN) return to IDLE from any state
//   q0, q_m1              Booth pair from the datapath, sampled only in CHECK
//   count                 iteration counter value (pre-increment)
//   load_regs, cnt_clr    datapath load / counter clear (LOAD state)
//   add_en, sub_en        A <= A +/- M
//   shift_en, cnt_en      arithmetic right shift of {A,Q,Q-1} and counter increment
//   busy, done            handshake: busy outside IDLE, done one-cycle pulse
//
// Optional feature macro: BOOTH_CTRL_ABORT_EN adds the abort input.

module booth_ctrl #(
  parameter int CNT_WIDTH  = 3,
  parameter int ITERATIONS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
`ifdef BOOTH_CTRL_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 q0,
  input  logic                 q_m1,
  input  logic [CNT_WIDTH-1:0] count,
  output logic                 load_regs,
  output logic                 cnt_clr,
  output logic                 add_en,
  output logic                 sub_en,
  output logic                 shift_en,
  output logic                 cnt_en,
  output logic                 busy,
  output logic                 done
);

  if (ITERATIONS < 1 || ITERATIONS > (1 << CNT_WIDTH)) begin : g_bad_params
    $error("booth_ctrl: ITERATIONS must be in 1..2**CNT_WIDTH");
  end

  // Termination compares the pre-increment count, so ITERATIONS == 2**CNT_WIDTH
  // still terminates even though the final increment wraps the counter to 0.
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ITERATIONS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SUB   = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: begin
        case ({q0, q_m1})
          2'b01:   state_d = S_ADD;
          2'b10:   state_d = S_SUB;
          default: state_d = S_SHIFT;
        endcase
      end
      S_ADD:   state_d = S_SHIFT;
      S_SUB:   state_d = S_SHIFT;
      S_SHIFT: state_d = (count == LAST_CNT) ? S_DONE : S_CHECK;
      S_DONE:  state_d = S_IDLE;
      // The spare encoding recovers to IDLE.
      default: state_d = S_IDLE;
    endcase
`ifdef BOOTH_CTRL_ABORT_EN
    // Abort outranks every transition, including a start sampled in IDLE.
    if (abort) begin
      state_d = S_IDLE;
    end
`endif
  end

  always_comb begin
    load_regs = 1'b0;
    cnt_clr   = 1'b0;
    add_en    = 1'b0;
    sub_en    = 1'b0;
    shift_en  = 1'b0;
    cnt_en    = 1'b0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_LOAD: begin
        load_regs = 1'b1;
        cnt_clr   = 1'b1;
      end
      S_ADD:   add_en = 1'b1;
      S_SUB:   sub_en = 1'b1;
      S_SHIFT: begin
        shift_en = 1'b1;
        cnt_en   = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
`ifdef BOOTH_CTRL_ABORT_EN
    // An aborted multiply never reports a product.
    if (abort) begin
      done = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: directed bench for booth_ctrl driven by a behavioural Booth datapath.
// Cycle n is the interval n rising edges after the edge that samples start.
// Outputs are sampled 1 time unit after each rising edge.

module tb_booth_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, q0, q_m1;
  logic [2:0] count;
  logic       load_regs, cnt_clr, add_en, sub_en, shift_en, cnt_en, busy, done;
`ifdef BOOTH_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif

  always #5 clk = ~clk;

  booth_ctrl #(.CNT_WIDTH(3), .ITERATIONS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef BOOTH_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .q0        (q0),
    .q_m1      (q_m1),
    .count     (count),
    .load_regs (load_regs),
    .cnt_clr   (cnt_clr),
    .add_en    (add_en),
    .sub_en    (sub_en),
    .shift_en  (shift_en),
    .cnt_en    (cnt_en),
    .busy      (busy),
    .done      (done)
  );

  // Behavioural datapath: A/Q/Q-1/M registers and the iteration counter.
  logic [7:0] dp_a = '0, dp_q = '0, dp_m = '0;
  logic       dp_qm1 = 1'b0;
  logic [2:0] dp_cnt = '0;
  logic [7:0] mcand = '0, mplier = '0;

  always @(posedge clk) begin
    if (load_regs) begin
      dp_a   <= '0;
      dp_q   <= mplier;
      dp_m   <= mcand;
      dp_qm1 <= 1'b0;
    end else if (add_en) begin
      dp_a <= dp_a + dp_m;
    end else if (sub_en) begin
      dp_a <= dp_a - dp_m;
    end else if (shift_en) begin
      {dp_a, dp_q, dp_qm1} <= {dp_a[7], dp_a, dp_q};
    end
    if (cnt_clr)     dp_cnt <= '0;
    else if (cnt_en) dp_cnt <= dp_cnt + 3'd1;
  end

  assign q0    = dp_q[0];
  assign q_m1  = dp_qm1;
  assign count = dp_cnt;

  wire [7:0]  outs    = {load_regs, cnt_clr, add_en, sub_en, shift_en, cnt_en, busy, done};
  wire [15:0] product = {dp_a, dp_q};

  int passed = 0, failed = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one multiply from a single-cycle start pulse and gathers strobe statistics.
  int r_done, r_adds, r_subs, r_shifts, r_cnts, r_busy, r_loads, r_viol;
  task automatic run_mult(input logic [7:0] mc, input logic [7:0] mp);
    mcand = mc; mplier = mp;
    r_done = -1; r_adds = 0; r_subs = 0; r_shifts = 0;
    r_cnts = 0; r_busy = 0; r_loads = 0; r_viol = 0;
    start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      step();
      if (n == 1) start = 1'b0;
      r_adds   += int'(add_en);
      r_subs   += int'(sub_en);
      r_shifts += int'(shift_en);
      r_cnts   += int'(cnt_en);
      r_busy   += int'(busy);
      r_loads  += int'(load_regs);
      if ((int'(load_regs) + int'(add_en) + int'(sub_en) + int'(shift_en)) > 1) r_viol++;
      if (done) begin
        r_done = n;
        break;
      end
    end
  endtask

  int d1, d2, nd, nl, ndone;
  logic idle_seen;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    step(); step(); step();
    chk("reset_outputs", 32'(outs), 32'h0);
    reset = 1'b0;
    step();
    chk("idle_no_start", 32'(outs), 32'h0);

    // Multiplier 0: every pair is 00, fastest path.
    run_mult(8'h2B, 8'h00);
    chk("m0_done_cycle", r_done, 18);
    chk("m0_adds", r_adds, 0);
    chk("m0_subs", r_subs, 0);
    chk("m0_shifts", r_shifts, 8);
    chk("m0_busy_cycles", r_busy, 18);
    chk("m0_onehot", r_viol, 0);
    chk("m0_product", 32'(product), 32'h0);
    step();
    chk("m0_after_done", 32'(outs), 32'h0);

    // 5 x 1: SUB in iteration 0, ADD in iteration 1.
    run_mult(8'h05, 8'h01);
    chk("m51_done_cycle", r_done, 20);
    chk("m51_subs", r_subs, 1);
    chk("m51_adds", r_adds, 1);
    chk("m51_product", 32'(product), 32'h0005);
    step();

    // -3 x 7.
    run_mult(8'hFD, 8'h07);
    chk("neg_product", 32'(product), 32'hFFEB);
    chk("neg_subs", r_subs, 1);
    chk("neg_adds", r_adds, 1);
    chk("neg_shifts", r_shifts, 8);
    chk("neg_cnt_en", r_cnts, 8);
    chk("neg_done_cycle", r_done, 20);
    chk("neg_onehot", r_viol, 0);
    step();

    // Reset in cycle 6 of a multiply.
    mcand = 8'h11; mplier = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 2; n <= 6; n++) step();
    chk("pre_reset_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    step();
    chk("reset_mid_outputs", 32'(outs), 32'h0);
    reset = 1'b0;
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      ndone += int'(done) + int'(busy);
    end
    chk("reset_mid_quiet", ndone, 0);
    run_mult(8'h09, 8'h03);
    chk("post_reset_done_cycle", r_done, 20);
    chk("post_reset_product", 32'(product), 32'h001B);
    step();

    // start held high: back-to-back multiplies with one IDLE cycle between.
    mcand = 8'h07; mplier = 8'h00;
    d1 = -1; d2 = -1; nd = 0; nl = 0;
    start = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      step();
      nl += int'(load_regs);
      if (done) begin
        nd++;
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
    end
    start = 1'b0;
    chk("b2b_first_done", d1, 18);
    chk("b2b_second_done", d2, 37);
    chk("b2b_done_count", nd, 2);
    chk("b2b_load_count", nl, 3);
    idle_seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
    end
    chk("b2b_returns_idle", 32'(idle_seen), 32'h1);
    step();

`ifdef BOOTH_CTRL_ABORT_EN
    // Abort during the ADD of 5 x 1 (cycle 6).
    mcand = 8'h05; mplier = 8'h01;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 2; n <= 6; n++) step();
    chk("abort_in_add", 32'(add_en), 32'h1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_outputs", 32'(outs), 32'h0);
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      ndone += int'(done) + int'(busy);
    end
    chk("abort_quiet", ndone, 0);
    // Abort in IDLE blocks a same-cycle start.
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_blocks_start", 32'(busy), 32'h0);
    step();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
